// File: rtl/median_sort_arbiter.sv
// median_sort_arbiter: round-robin arbiter that shares one 9-input sorter
// between NUM_REQ 3x3 window requesters and returns the median to the winner.
// Optional feature macro: MEDIAN_ARB_TIMEOUT_EN (RUN-state watchdog with ABORT).
`ifndef BITWIDTH
`define BITWIDTH 8
`endif

module median_sort_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 63
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [NUM_REQ-1:0]              req_i,
    input  logic [NUM_REQ*9*`BITWIDTH-1:0]  win_data_i,
    output logic [NUM_REQ-1:0]              grant_o,
    output logic [NUM_REQ-1:0]              ack_o,
    output logic [`BITWIDTH-1:0]            median_o,
    output logic                            median_valid_o,
    output logic [1:0]                      req_id_o,
    output logic                            sort_start_o,
    output logic [9*`BITWIDTH-1:0]          sort_data_o,
    input  logic                            sort_valid_i,
    input  logic [`BITWIDTH-1:0]            sort_median_i,
    output logic                            err_o
);
    localparam int BW = `BITWIDTH;
    localparam int WW = 9 * BW;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_RUN      = 3'd2;
    localparam logic [2:0] S_DONE     = 3'd3;
    localparam logic [2:0] S_WAIT_CLR = 3'd4;
    localparam logic [2:0] S_ABORT    = 3'd5;

    logic [2:0]         state_q, state_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [1:0]         id_q, id_d;
    logic [WW-1:0]      win_q, win_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [BW-1:0]      median_q, median_d;
    logic [1:0]         req_id_q, req_id_d;

    logic [NUM_REQ-1:0] hi_req;
    logic [1:0]         pick;
    logic [WW-1:0]      sel_win;
    logic [1:0]         ptr_next;
    logic               ack_pulse;

`ifdef MEDIAN_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

    // Round-robin pick: lowest requester at/above the pointer, else lowest overall.
    always_comb begin
        pick   = ptr_q;
        hi_req = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            hi_req[j] = req_i[j] && (j >= int'(ptr_q));
        end
        if (|hi_req) begin
            for (int j = NUM_REQ - 1; j >= 0; j--) begin
                if (hi_req[j]) pick = 2'(j);
            end
        end else begin
            for (int j = NUM_REQ - 1; j >= 0; j--) begin
                if (req_i[j]) pick = 2'(j);
            end
        end
    end

    // Mux the winner's window out of the flattened request bus.
    always_comb begin
        sel_win = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (pick == 2'(j)) sel_win = win_data_i[j*WW +: WW];
        end
    end

    assign ptr_next = (id_q == 2'(NUM_REQ - 1)) ? 2'd0 : id_q + 2'd1;

    // Next-state and datapath updates for the handshake with the sorter.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        win_d    = win_q;
        grant_d  = grant_q;
        median_d = median_q;
        req_id_d = req_id_q;
`ifdef MEDIAN_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (|req_i) begin
                    win_d = sel_win;
                    id_d  = pick;
                    for (int j = 0; j < NUM_REQ; j++) grant_d[j] = (pick == 2'(j));
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
`ifdef MEDIAN_ARB_TIMEOUT_EN
                cnt_d = '0;
`endif
                state_d = S_RUN;
            end
            S_RUN: begin
                if (sort_valid_i) begin
                    median_d = sort_median_i;
                    req_id_d = id_q;
                    state_d  = S_DONE;
                end
`ifdef MEDIAN_ARB_TIMEOUT_EN
                else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_ABORT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_DONE: begin
                ptr_d   = ptr_next;
                grant_d = '0;
                state_d = S_WAIT_CLR;
            end
`ifdef MEDIAN_ARB_TIMEOUT_EN
            S_ABORT: begin
                ptr_d   = ptr_next;
                grant_d = '0;
                state_d = S_WAIT_CLR;
            end
`endif
            S_WAIT_CLR: begin
                if (!sort_valid_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and latch registers; reset returns everything to zero/IDLE.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            id_q     <= '0;
            win_q    <= '0;
            grant_q  <= '0;
            median_q <= '0;
            req_id_q <= '0;
`ifdef MEDIAN_ARB_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            id_q     <= id_d;
            win_q    <= win_d;
            grant_q  <= grant_d;
            median_q <= median_d;
            req_id_q <= req_id_d;
`ifdef MEDIAN_ARB_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

`ifdef MEDIAN_ARB_TIMEOUT_EN
    assign ack_pulse = (state_q == S_DONE) || (state_q == S_ABORT);
    assign err_o     = (state_q == S_ABORT);
`else
    assign ack_pulse = (state_q == S_DONE);
    assign err_o     = 1'b0;
`endif

    // Completion pulse goes only to the recorded owner.
    always_comb begin
        ack_o = '0;
        for (int j = 0; j < NUM_REQ; j++) ack_o[j] = ack_pulse && (id_q == 2'(j));
    end

    assign grant_o        = grant_q;
    assign median_o       = median_q;
    assign req_id_o       = req_id_q;
    assign median_valid_o = (state_q == S_DONE);
    assign sort_start_o   = (state_q == S_RUN);
    assign sort_data_o    = win_q;

endmodule

// File: tb/tb_median_sort_arbiter.sv
// Self-checking bench for median_sort_arbiter with a behavioural sorter stub.
`ifndef BITWIDTH
`define BITWIDTH 8
`endif

module tb_median_sort_arbiter;
    localparam int BW = `BITWIDTH;
    localparam int WW = 9 * BW;
`ifdef MEDIAN_ARB_TIMEOUT_EN
    localparam int TO = 10;
`else
    localparam int TO = 63;
`endif

    logic            CLK = 1'b0;
    logic            RST;
    logic [3:0]      req;
    logic [4*WW-1:0] win;
    logic [3:0]      grant_o, ack_o;
    logic [BW-1:0]   median_o;
    logic            median_valid_o;
    logic [1:0]      req_id_o;
    logic            sort_start_o;
    logic [WW-1:0]   sort_data_o;
    logic            sort_valid;
    logic [BW-1:0]   sort_median;
    logic            err_o;

    int vectors = 0;
    int miscompares = 0;
    int mptr = 0;
    bit stub_dead = 1'b0;

    median_sort_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RST(RST), .req_i(req), .win_data_i(win),
        .grant_o(grant_o), .ack_o(ack_o), .median_o(median_o),
        .median_valid_o(median_valid_o), .req_id_o(req_id_o),
        .sort_start_o(sort_start_o), .sort_data_o(sort_data_o),
        .sort_valid_i(sort_valid), .sort_median_i(sort_median), .err_o(err_o)
    );

    always #5 CLK = ~CLK;

    function automatic logic [BW-1:0] median9(input logic [WW-1:0] w);
        int a[9];
        int t;
        for (int i = 0; i < 9; i++) a[i] = int'(w[i*BW +: BW]);
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
        return BW'(a[4]);
    endfunction

    function automatic logic [WW-1:0] pk(input int p0, p1, p2, p3, p4, p5, p6, p7, p8);
        int p[9];
        logic [WW-1:0] w;
        p = '{p0, p1, p2, p3, p4, p5, p6, p7, p8};
        for (int i = 0; i < 9; i++) w[i*BW +: BW] = BW'(p[i]);
        return w;
    endfunction

    // Nine distinct pixels scattered around m; median is m (m in 4..251).
    function automatic logic [WW-1:0] mk_win(input int m);
        return pk(m+4, m-3, m+1, m-4, m, m+3, m-2, m+2, m-1);
    endfunction

    function automatic int rr_pick(input logic [3:0] mask, input int ptr);
        for (int i = 0; i < 4; i++)
            if (mask[(ptr + i) % 4]) return (ptr + i) % 4;
        return -1;
    endfunction

    // Sorter stub: captures on start, 36 sort cycles, holds valid until start drops.
    logic [1:0] sst;
    int         scnt;
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sst <= 2'd0; scnt <= 0; sort_valid <= 1'b0; sort_median <= '0;
        end else begin
            case (sst)
                2'd0: if (sort_start_o && !stub_dead) begin
                    sort_median <= median9(sort_data_o); scnt <= 0; sst <= 2'd1;
                end
                2'd1: begin
                    scnt <= scnt + 1;
                    if (scnt == 35) begin sst <= 2'd2; sort_valid <= 1'b1; end
                end
                default: if (!sort_start_o) begin sort_valid <= 1'b0; sst <= 2'd0; end
            endcase
        end
    end

    // Whenever the sorter is owned, exactly one grant bit may be set.
    always @(negedge CLK) begin
        if (RST === 1'b1 && grant_o !== 4'b0) begin
            vectors++;
            if (!$onehot(grant_o)) begin
                miscompares++;
                $display("FAIL grant_onehot: got %b want one-hot", grant_o);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        RST = 1'b0; req = '0;
        @(negedge CLK); @(negedge CLK);
        RST = 1'b1; mptr = 0;
    endtask

    // One request/ack transaction starting from IDLE at a negedge.
    task automatic run_op(input string nm, input logic [3:0] r, input int exp_id,
                          input logic [WW-1:0] exp_w, input int exp_med, input bit drop);
        int n;
        bit seen;
        n = 1; seen = 1'b0;
        req = r;
        @(negedge CLK);
        chk({nm, "_grant"}, grant_o, 32'(1 << exp_id));
        chk({nm, "_sdata"}, sort_data_o, exp_w);
        if (drop) begin
            req = '0;
            win[exp_id*WW +: WW] = pk(1, 1, 1, 1, 1, 1, 1, 1, 1);
        end
        while (n < 200 && !seen) begin
            @(negedge CLK); n++;
            if (median_valid_o) seen = 1'b1;
        end
        if (!seen) begin
            vectors++; miscompares++;
            $display("FAIL %s_timeout: got no median_valid in %0d cycles want 40", nm, n);
        end else begin
            chk({nm, "_lat"}, n, 40);
            chk({nm, "_med"}, median_o, exp_med);
            chk({nm, "_id"}, req_id_o, exp_id);
            chk({nm, "_ack"}, ack_o, 32'(1 << exp_id));
        end
        req = '0;
        @(negedge CLK);
        chk({nm, "_ackclr"}, {grant_o, ack_o, 3'b0, median_valid_o}, 0);
        @(negedge CLK);
        mptr = (exp_id + 1) % 4;
    endtask

    typedef struct {
        logic [3:0]    req;
        logic [WW-1:0] w;
        int            exp_id;
        int            exp_med;
    } vec_t;

    initial begin
        vec_t tbl[8];
        int last_n, n, cnt, id0, id1;
        bit seen;
        logic [3:0] r;

        tbl[0] = '{4'b0001, pk(9, 3, 7, 1, 5, 8, 2, 6, 4), 0, 5};
        tbl[1] = '{4'b0010, mk_win(100), 1, 100};
        tbl[2] = '{4'b0011, mk_win(50),  0, 50};   // pointer 2 wraps to 0
        tbl[3] = '{4'b0010, mk_win(60),  1, 60};
        tbl[4] = '{4'b1100, mk_win(70),  2, 70};
        tbl[5] = '{4'b1101, mk_win(80),  3, 80};
        tbl[6] = '{4'b1000, mk_win(4),   3, 4};    // pixel values 0..8
        tbl[7] = '{4'b0100, mk_win(251), 2, 251};  // pixel values up to 255

        RST = 1'b0; req = '0; win = '0;
        @(negedge CLK); @(negedge CLK);
        chk("rst_grant", grant_o, 0);
        chk("rst_ack", ack_o, 0);
        chk("rst_med", median_o, 0);
        chk("rst_mv", median_valid_o, 0);
        chk("rst_start", sort_start_o, 0);
        chk("rst_err", err_o, 0);
        RST = 1'b1;

        // Table-driven single transactions from a fresh reset.
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 4; k++)
                win[k*WW +: WW] = (k == tbl[i].exp_id) ? tbl[i].w : mk_win(200 + 10 * k);
            run_op($sformatf("tbl%0d", i), tbl[i].req, tbl[i].exp_id, tbl[i].w, tbl[i].exp_med, 1'b0);
        end

        // All four requesting continuously: order 0,1,2,3,0 every 42 cycles.
        do_reset();
        for (int k = 0; k < 4; k++) win[k*WW +: WW] = mk_win(10 * (k + 1));
        req = 4'b1111;
        last_n = 0; n = 0;
        for (int j = 0; j < 5; j++) begin
            seen = 1'b0; cnt = 0;
            while (cnt < 100 && !seen) begin
                @(negedge CLK); n++; cnt++;
                if (median_valid_o) seen = 1'b1;
            end
            if (!seen) begin
                vectors++; miscompares++;
                $display("FAIL b2b%0d_timeout: got none want ack", j);
            end else begin
                chk($sformatf("b2b%0d_gap", j), n - last_n, (j == 0) ? 40 : 42);
                chk($sformatf("b2b%0d_id", j), req_id_o, j % 4);
                chk($sformatf("b2b%0d_med", j), median_o, 10 * (j % 4 + 1));
                chk($sformatf("b2b%0d_ack", j), ack_o, 32'(1 << (j % 4)));
            end
            last_n = n;
        end
        req = '0;
        @(negedge CLK); @(negedge CLK);
        mptr = 1;

        // Window changed and request dropped right after grant.
        win[1*WW +: WW] = mk_win(120);
        run_op("drop", 4'b0010, 1, mk_win(120), 120, 1'b1);
        cnt = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge CLK);
            if (median_valid_o || ack_o != 0) cnt++;
        end
        chk("drop_noreack", cnt, 0);

        // Reset asserted while the sorter is running.
        win[2*WW +: WW] = mk_win(77);
        req = 4'b0100;
        for (int c = 0; c < 10; c++) @(negedge CLK);
        chk("mid_start", sort_start_o, 1);
        RST = 1'b0; req = '0;
        #1;
        chk("midrst_outs", {grant_o, ack_o, median_valid_o, req_id_o, sort_start_o, err_o}, 0);
        chk("midrst_med", median_o, 0);
        chk("midrst_data", sort_data_o, 0);
        @(negedge CLK);
        RST = 1'b1; mptr = 0;
        run_op("postrst", 4'b0110, 1, win[1*WW +: WW], 120 - 120 + int'(median9(win[1*WW +: WW])), 1'b0);

        // Randomized traffic against the round-robin/median reference model.
        for (int i = 0; i < 24; i++) begin
            r = 4'($urandom_range(1, 15));
            for (int k = 0; k < 4; k++)
                for (int p = 0; p < 9; p++) win[k*WW + p*BW +: BW] = BW'($urandom);
            id0 = rr_pick(r, mptr);
            run_op($sformatf("rnd%0d", i), r, id0, win[id0*WW +: WW],
                   int'(median9(win[id0*WW +: WW])), 1'b0);
        end

`ifdef MEDIAN_ARB_TIMEOUT_EN
        // Sorter never answers: ABORT after TO RUN cycles, next requester granted.
        stub_dead = 1'b1;
        id0 = rr_pick(4'b0011, mptr);
        id1 = 1 - id0;
        req = 4'b0011;
        n = 0; seen = 1'b0; cnt = 0;
        while (n < 100 && !seen) begin
            @(negedge CLK); n++;
            if (median_valid_o) cnt++;
            if (err_o) seen = 1'b1;
        end
        if (!seen) begin
            vectors++; miscompares++;
            $display("FAIL to_err: got no err_o in %0d cycles want pulse", n);
        end else begin
            chk("to_lat", n, TO + 2);
            chk("to_ack", ack_o, 32'(1 << id0));
        end
        req[id0] = 1'b0;
        seen = 1'b0; n = 0;
        while (n < 10 && !seen) begin
            @(negedge CLK); n++;
            if (median_valid_o) cnt++;
            if (grant_o != 0) seen = 1'b1;
        end
        chk("to_next_grant", grant_o, 32'(1 << id1));
        chk("to_no_mv", cnt, 0);
        stub_dead = 1'b0;
        do_reset();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
